seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
- Multi-cycle RV32M multiply unit on the far side of the ALU's MUL_EN request.
- When the ALU flags an M-extension multiply, this block captures the operands and iterates a shift-add product. It stalls the pipeline via `busy` and returns the selected 32-bit half with a one-cycle `done` pulse.
- It sits beside the ALU in execute; its result is muxed onto the writeback path when `done` is high.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8.
- ITER, 32/BITS_PER_CYCLE, derived local constant; number of CALC cycles.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- MUL_EN  input  1  multiply request from ALU; level-sensitive.
- src_A  input  32  rs1 operand.
- src_B  input  32  rs2 operand.
- instruction  input  32  current instruction; only funct3 = instruction[14:12] is used.
- flush  input  1  synchronous abort; pipeline is squashing the instruction.
- busy  output  1  stall request = MUL_EN & ~done (combinational).
- done  output  1  one-cycle pulse; mul_result valid.
- mul_result  output  32  product half selected by funct3.

Behaviour:
- Reset: one clock, asynchronous active-low n_rst. Asserting n_rst forces state=IDLE, done=0, mul_result=0 and all internal registers to 0, at any time including mid-CALC.
- FSM states: IDLE, CALC, FIN, DONE.
- IDLE:
  - If MUL_EN=1 and flush=0, latch src_A, src_B and funct3, clear the count and go to CALC.
  - Operand conversion: signed operands are converted to magnitude. MUL/MULH: both signed. MULHSU: A signed, B unsigned. MULHU: both unsigned.
  - Record neg = sign(A) ^ sign(B), using only the operands treated as signed.
- Zero shortcut: if either latched magnitude is 0, IDLE goes to FIN directly, skipping CALC.
- CALC: each cycle add (A_mag × next BITS_PER_CYCLE bits of B_mag) into a 64-bit accumulator and shift. After ITER cycles, go to FIN.
- FIN:
  - Apply two's-complement negate to the 64-bit product if neg=1.
  - Select the half: 000 MUL → low 32. 001 MULH, 010 MULHSU, 011 MULHU → high 32.
  - Register mul_result and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: done is high in cycle ITER+2 counted from the IDLE cycle that sampled MUL_EN=1 (34 by default). Zero shortcut: 2.
- Unsupported funct3 (1xx, divide ops): IDLE goes to FIN without CALC; mul_result=0; done pulses at latency 2.
- MUL_EN handling:
  - MUL_EN is ignored outside IDLE; operands are not re-sampled mid-operation.
  - The pipeline advances on done, so MUL_EN sampled in the cycle after DONE belongs to the next instruction. This gives back-to-back multiplies with no idle gap beyond the DONE→IDLE cycle.
- mul_result holds its value after DONE until the next FIN; it is not cleared in IDLE.
- flush:
  - flush=1 in CALC or FIN returns to IDLE next edge with no done and mul_result unchanged.
  - flush=1 in DONE: done still pulses (the result is discarded by the pipeline).
  - flush=1 with MUL_EN in IDLE: not accepted.
- MUL_EN dropping mid-CALC without flush is a protocol violation; the block completes and pulses done regardless.
- Width rules:
  - Accumulator is 64 bit unsigned and never overflows, since magnitudes are at most 2^32 and the product is under 2^64.
  - Negation is 64-bit wrap-around. The most negative × most negative case (0x80000000 × 0x80000000) is exact.

Decomposition:
- Package mul_pkg holds:
  - state enum (IDLE, CALC, FIN, DONE);
  - funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU;
  - OPCODE_OP = 7'b0110011 and FUNCT7_MULDIV = 7'b0000001, shared with the ALU decode.
- One sub-module is natural: mul_partial_add, a combinational BITS_PER_CYCLE-wide partial-product adder step, instantiated once in CALC.
- Control stays in seq_multiplier.

Test Plan:
- MUL, src_A=6, src_B=7, MUL_EN held high → busy=1 for cycles 0–33; done pulse at cycle 34 with mul_result=42; busy=0 in that cycle.
- MUL −5 × 3 (0xFFFFFFFB, 3) → mul_result=0xFFFFFFF1.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Zero shortcut: MUL 0 × 123 → done at cycle 2, mul_result=0. Unsupported funct3=100 → done at cycle 2, mul_result=0.
- Abort: start MUL 100 × 50, pulse flush at cycle 10 → no done, returns to IDLE, mul_result holds its prior value. Repeat with n_rst low at cycle 10 → mul_result=0 and done=0 immediately.
- Back-to-back: after the first 100 × 50 = 5000 completes, MUL_EN stays high with new operands 3 × 4 → a second done at cycle 34 relative to its acceptance, mul_result=12. No spurious double-capture of the first operands.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the RV32M sequential multiplier and the ALU decode.
package mul_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PLEN = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // rs1 is treated as signed for MUL, MULH and MULHSU
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU);
  endfunction

  // rs2 is treated as signed for MUL and MULH only
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH);
  endfunction

endpackage

// File: rtl/mul_partial_add.sv
// One shift-add step: adds a_i weighted by each bit of b_i into the running accumulator.
module mul_partial_add
  import mul_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [PLEN-1:0]           acc_i,
  input  logic [PLEN-1:0]           a_i,
  input  logic [BITS_PER_CYCLE-1:0] b_i,
  output logic [PLEN-1:0]           sum_o
);

  always_comb begin
    sum_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_i[i]) begin
        sum_o = sum_o + (a_i << i);
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle RV32M multiply unit: magnitude shift-add product, sign fix-up and half select.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            MUL_EN,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  input  logic [XLEN-1:0] instruction,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] mul_result
);

  localparam int unsigned ITER  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITER) + 1;

  state_e            state_q, state_d;
  logic [PLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [PLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  logic [2:0]        funct3;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [PLEN-1:0]   step_sum;
  logic [PLEN-1:0]   prod;
  logic              unused_instr;

  assign funct3       = instruction[14:12];
  assign unused_instr = ^{instruction[31:15], instruction[11:0]};

  // Operand magnitudes, only negating operands the op treats as signed
  assign a_sgn = a_is_signed(funct3) & src_A[XLEN-1];
  assign b_sgn = b_is_signed(funct3) & src_B[XLEN-1];
  assign a_mag = a_sgn ? (~src_A + XLEN'(1)) : src_A;
  assign b_mag = b_sgn ? (~src_B + XLEN'(1)) : src_B;

  assign prod = neg_q ? (~acc_q + PLEN'(1)) : acc_q;

  mul_partial_add #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q[BITS_PER_CYCLE-1:0]),
    .sum_o (step_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    res_d   = res_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MUL_EN && !flush) begin
          f3_d  = funct3;
          cnt_d = '0;
          acc_d = '0;
          a_d   = PLEN'(a_mag);
          b_d   = b_mag;
          neg_d = a_sgn ^ b_sgn;
          if (funct3[2]) begin
            // Divide encodings are not handled here: report a zero result quickly
            neg_d   = 1'b0;
            state_d = FIN;
          end else if ((a_mag == '0) || (b_mag == '0)) begin
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_sum;
          a_d   = a_q << BITS_PER_CYCLE;
          b_d   = b_q >> BITS_PER_CYCLE;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          unique case (f3_q)
            F3_MUL:                       res_d = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_d = prod[PLEN-1:XLEN];
            default:                      res_d = '0;
          endcase
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign done       = done_q;
  assign mul_result = res_q;
  assign busy       = MUL_EN & ~done_q;

endmodule
